// File: rtl/or1200_insn_monitor.sv
`default_nettype none
// ============================================================================
// Module   : or1200_insn_monitor
// Purpose  : Passive observer of the OR1200 write-back instruction stream.
//            Decodes l.nop K simulation hooks (exit, report r3, putc r3[7:0])
//            into registered one-cycle event pulses with captured data, and
//            counts retired instructions and recognised hooks. Drives nothing
//            back into the CPU.
// Ports    : clk            - system clock, rising edge
//            rst_n          - asynchronous active-low reset
//            wb_insn        - instruction word in write-back
//            wb_valid       - wb_insn retires this cycle
//            gpr_r3         - current value of GPR r3
//            exit_valid     - one-cycle pulse on exit hook
//            exited         - sticky, set on exit hook
//            exit_code      - r3 captured at exit
//            report_valid   - one-cycle pulse on report hook
//            report_data    - r3 captured at report
//            putc_valid     - one-cycle pulse on putc hook
//            putc_char      - r3[7:0] captured at putc
//            insn_count     - retired instruction count (wraps)
//            nop_hook_count - recognised hook count (saturates)
// Revision : 1.0 - initial release
// ============================================================================
module or1200_insn_monitor #(
  parameter int          ENABLE_DISPLAY = 0,
  parameter logic [15:0] NOP_EXIT       = 16'h0001,
  parameter logic [15:0] NOP_REPORT     = 16'h0002,
  parameter logic [15:0] NOP_PUTC       = 16'h0004
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] wb_insn,
  input  logic        wb_valid,
  input  logic [31:0] gpr_r3,
  output logic        exit_valid,
  output logic        exited,
  output logic [31:0] exit_code,
  output logic        report_valid,
  output logic [31:0] report_data,
  output logic        putc_valid,
  output logic [7:0]  putc_char,
  output logic [31:0] insn_count,
  output logic [15:0] nop_hook_count
);

  localparam logic [7:0]  C_NOP_OPC   = 8'h15;
  localparam logic [15:0] C_HOOK_SAT  = 16'hFFFF;

  logic        w_active;
  logic        w_is_nop;
  logic [15:0] w_k;
  logic        w_exit_hit;
  logic        w_report_hit;
  logic        w_putc_hit;
  logic        w_hook_hit;

  // Once the exit hook has been seen the monitor freezes completely, so
  // every retirement is qualified by the sticky exited flag.
  assign w_active     = wb_valid && !exited;
  assign w_is_nop     = (wb_insn[31:24] == C_NOP_OPC) && (wb_insn[23:16] == 8'h00);
  assign w_k          = wb_insn[15:0];
  assign w_exit_hit   = w_active && w_is_nop && (w_k == NOP_EXIT);
  assign w_report_hit = w_active && w_is_nop && (w_k == NOP_REPORT);
  assign w_putc_hit   = w_active && w_is_nop && (w_k == NOP_PUTC);
  assign w_hook_hit   = w_exit_hit || w_report_hit || w_putc_hit;

  // Event pulses and captured data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exit_valid   <= 1'b0;
      exited       <= 1'b0;
      exit_code    <= 32'h0;
      report_valid <= 1'b0;
      report_data  <= 32'h0;
      putc_valid   <= 1'b0;
      putc_char    <= 8'h0;
    end else begin
      exit_valid   <= w_exit_hit;
      report_valid <= w_report_hit;
      putc_valid   <= w_putc_hit;
      if (w_exit_hit) begin
        exited    <= 1'b1;
        exit_code <= gpr_r3;
      end
      if (w_report_hit) begin
        report_data <= gpr_r3;
      end
      if (w_putc_hit) begin
        putc_char <= gpr_r3[7:0];
      end
    end
  end

  // Counters: instruction count wraps naturally, hook count saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      insn_count     <= 32'h0;
      nop_hook_count <= 16'h0;
    end else begin
      if (w_active) begin
        insn_count <= insn_count + 32'd1;
      end
      if (w_hook_hit && (nop_hook_count != C_HOOK_SAT)) begin
        nop_hook_count <= nop_hook_count + 16'd1;
      end
    end
  end

`ifndef SYNTHESIS
  generate
    if (ENABLE_DISPLAY != 0) begin : g_display
      always @(posedge clk) begin
        if (rst_n) begin
          if (w_report_hit) begin
            $display("report(0x%08h);", gpr_r3);
          end
          if (w_putc_hit) begin
            $write("%c", gpr_r3[7:0]);
          end
          if (w_exit_hit) begin
            $display("exit(0x%08h)", gpr_r3);
            $finish;
          end
        end
      end
    end : g_display
  endgenerate
`endif

endmodule : or1200_insn_monitor
`default_nettype wire

// File: tb/tb_or1200_insn_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_or1200_insn_monitor
// Purpose  : Directed-vector bench for or1200_insn_monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_or1200_insn_monitor;

  logic        clk;
  logic        rst_n;
  logic [31:0] wb_insn;
  logic        wb_valid;
  logic [31:0] gpr_r3;
  logic        exit_valid;
  logic        exited;
  logic [31:0] exit_code;
  logic        report_valid;
  logic [31:0] report_data;
  logic        putc_valid;
  logic [7:0]  putc_char;
  logic [31:0] insn_count;
  logic [15:0] nop_hook_count;

  int n_vec;
  int n_err;

  or1200_insn_monitor #(
    .ENABLE_DISPLAY (0),
    .NOP_EXIT       (16'h0001),
    .NOP_REPORT     (16'h0002),
    .NOP_PUTC       (16'h0004)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wb_insn        (wb_insn),
    .wb_valid       (wb_valid),
    .gpr_r3         (gpr_r3),
    .exit_valid     (exit_valid),
    .exited         (exited),
    .exit_code      (exit_code),
    .report_valid   (report_valid),
    .report_data    (report_data),
    .putc_valid     (putc_valid),
    .putc_char      (putc_char),
    .insn_count     (insn_count),
    .nop_hook_count (nop_hook_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Apply one instruction, then sample 1 time unit after the rising edge
  task automatic step(input logic [31:0] insn, input logic valid, input logic [31:0] r3);
    wb_insn  = insn;
    wb_valid = valid;
    gpr_r3   = r3;
    @(posedge clk);
    #1;
  endtask

  task automatic check_pulses(input string tag, input logic [2:0] exp_erp);
    check({tag, ".exit_valid"},   {31'b0, exit_valid},   {31'b0, exp_erp[2]});
    check({tag, ".report_valid"}, {31'b0, report_valid}, {31'b0, exp_erp[1]});
    check({tag, ".putc_valid"},   {31'b0, putc_valid},   {31'b0, exp_erp[0]});
  endtask

  initial begin
    int rep_pulses;
    logic [7:0] chars [3];
    chars[0] = 8'h48;
    chars[1] = 8'h69;
    chars[2] = 8'h0A;
    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b1;
    wb_insn  = 32'h0;
    wb_valid = 1'b0;
    gpr_r3   = 32'h0;
    #1 rst_n = 1'b0;

    // Reset held with live, retiring hook traffic
    for (int i = 0; i < 4; i++) begin
      step((i % 2 == 0) ? 32'h15000002 : 32'h15000001, 1'b1, 32'hDEADBEEF);
    end
    check_pulses("rst", 3'b000);
    check("rst.exited",    {31'b0, exited}, 32'h0);
    check("rst.exit_code", exit_code,       32'h0);
    check("rst.report_data", report_data,   32'h0);
    check("rst.putc_char", {24'b0, putc_char}, 32'h0);
    check("rst.insn_count", insn_count,     32'h0);
    check("rst.hook_count", {16'b0, nop_hook_count}, 32'h0);

    // Release between edges, retire three ordinary instructions
    wb_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(32'h14410000, 1'b1, 32'h0);
      check_pulses("plain", 3'b000);
    end
    check("plain.insn_count", insn_count, 32'd3);
    check("plain.hook_count", {16'b0, nop_hook_count}, 32'd0);

    // Report hook
    step(32'h15000002, 1'b1, 32'h8000_0000);
    check_pulses("report", 3'b010);
    check("report.data", report_data, 32'h8000_0000);
    check("report.hook_count", {16'b0, nop_hook_count}, 32'd1);
    step(32'h15000002, 1'b0, 32'h1234_5678);
    check_pulses("report.after", 3'b000);
    check("report.hold", report_data, 32'h8000_0000);

    // Putc stream, back-to-back
    for (int i = 0; i < 3; i++) begin
      step(32'h15000004, 1'b1, {24'hABCDEF, chars[i]});
      check_pulses("putc", 3'b001);
      check("putc.char", {24'b0, putc_char}, {24'b0, chars[i]});
    end
    step(32'h0, 1'b0, 32'h0);
    check_pulses("putc.after", 3'b000);
    check("putc.hold", {24'b0, putc_char}, 32'h0A);
    check("putc.hook_count", {16'b0, nop_hook_count}, 32'd4);
    check("putc.insn_count", insn_count, 32'd7);

    // Stall: held hook, only one retiring cycle
    rep_pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step(32'h15000002, (i == 0), 32'h0000_0055);
      if (report_valid) rep_pulses++;
    end
    check("stall.pulses", rep_pulses, 32'd1);
    check("stall.insn_count", insn_count, 32'd8);
    check("stall.hook_count", {16'b0, nop_hook_count}, 32'd5);
    check("stall.data", report_data, 32'h0000_0055);

    // Non-hook l.nop variants
    step(32'h15000003, 1'b1, 32'h1);
    check_pulses("nonhook.k3", 3'b000);
    step(32'h15010002, 1'b1, 32'h2);
    check_pulses("nonhook.rb", 3'b000);
    step(32'h15000000, 1'b1, 32'h3);
    check_pulses("nonhook.k0", 3'b000);
    check("nonhook.hook_count", {16'b0, nop_hook_count}, 32'd5);
    check("nonhook.insn_count", insn_count, 32'd11);
    check("nonhook.report_data", report_data, 32'h0000_0055);

    // Exit
    step(32'h15000001, 1'b1, 32'h0000_002A);
    check_pulses("exit", 3'b100);
    check("exit.exited", {31'b0, exited}, 32'h1);
    check("exit.code", exit_code, 32'd42);
    check("exit.insn_count", insn_count, 32'd12);
    check("exit.hook_count", {16'b0, nop_hook_count}, 32'd6);

    // Frozen after exit
    step(32'h15000002, 1'b1, 32'h7777_7777);
    check_pulses("frozen.report", 3'b000);
    step(32'h15000001, 1'b1, 32'h0000_0099);
    check_pulses("frozen.exit", 3'b000);
    step(32'h15000004, 1'b1, 32'h0000_0041);
    check_pulses("frozen.putc", 3'b000);
    check("frozen.exited", {31'b0, exited}, 32'h1);
    check("frozen.code", exit_code, 32'd42);
    check("frozen.report_data", report_data, 32'h0000_0055);
    check("frozen.putc_char", {24'b0, putc_char}, 32'h0A);
    check("frozen.insn_count", insn_count, 32'd12);
    check("frozen.hook_count", {16'b0, nop_hook_count}, 32'd6);

    // Asynchronous reset mid-operation, checked before any clock edge
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("areset.exited", {31'b0, exited}, 32'h0);
    check("areset.code", exit_code, 32'h0);
    check("areset.report_data", report_data, 32'h0);
    check("areset.insn_count", insn_count, 32'h0);
    check("areset.hook_count", {16'b0, nop_hook_count}, 32'h0);

    // Recovery after reset
    wb_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(32'h15000002, 1'b1, 32'hCAFE_F00D);
    check_pulses("recover", 3'b010);
    check("recover.data", report_data, 32'hCAFE_F00D);
    check("recover.insn_count", insn_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_or1200_insn_monitor
`default_nettype wire

// File: doc/or1200_insn_monitor.md
Name: or1200_insn_monitor

Overview:
- Passive, synthesizable observer of the OR1200 write-back stage instruction stream.
- Decodes l.nop K "simulation hooks" and exposes them as registered event outputs:
  - K=1: exit
  - K=2: report r3
  - K=4: putc r3[7:0]
- Counts retired instructions and l.nop hooks.
- Sits beside the CPU inside the SoC bench. It has no effect on the CPU and drives nothing back into it.

Parameters:
- ENABLE_DISPLAY, 0: when 1, simulation-only code prints events and calls $finish on exit. It is excluded from synthesis and has no effect on port behaviour.
- NOP_EXIT, 16'h0001: l.nop immediate meaning terminate, exit code = r3.
- NOP_REPORT, 16'h0002: l.nop immediate meaning report r3.
- NOP_PUTC, 16'h0004: l.nop immediate meaning print character r3[7:0].

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wb_insn  input  32  instruction word currently in write-back.
- wb_valid  input  1  1 = wb_insn retires this cycle (low when frozen, stalled or flushed).
- gpr_r3  input  32  current value of GPR r3.
- exit_valid  output  1  one-cycle pulse on exit hook.
- exited  output  1  sticky; set on exit hook.
- exit_code  output  32  r3 captured at exit.
- report_valid  output  1  one-cycle pulse on report hook.
- report_data  output  32  r3 captured at report.
- putc_valid  output  1  one-cycle pulse on putc hook.
- putc_char  output  8  r3[7:0] captured at putc.
- insn_count  output  32  number of retired instructions.
- nop_hook_count  output  16  number of recognised hook l.nops (K=1, 2 or 4).

Behaviour:
- Decode: an instruction is a hook l.nop when wb_valid=1, wb_insn[31:24]=8'h15 and wb_insn[23:16]=8'h00. K = wb_insn[15:0].
  - Any other K, including 0, is an ordinary instruction and produces no event.
- Reset (rst_n low, asynchronous): every output goes to 0 immediately and stays 0 while rst_n is low.
- Latency: all outputs are registered. An event retiring at edge N appears after edge N and is valid for exactly one cycle. Data is sampled from gpr_r3 at the same edge.
- insn_count: increments by 1 on every edge with wb_valid=1. Wraps from 0xFFFFFFFF to 0.
- nop_hook_count: increments on each recognised hook. Saturates at 0xFFFF.
- Exit:
  - The exit hook pulses exit_valid, sets exited and loads exit_code.
  - Once exited=1, no further hooks, pulses or counter updates occur; only reset clears it.
  - An exit hook while exited=1 is ignored.
- Report: pulses report_valid and loads report_data. report_data holds its value until the next report.
- Putc: pulses putc_valid and loads putc_char. putc_char holds its value until the next putc.
- Back-to-back: consecutive retiring hooks produce consecutive pulses. Nothing is dropped or merged.
- Stalls: a wb_insn held for several cycles with wb_valid=0 produces no repeat events.
- Only one instruction retires per cycle, so at most one event pulse is high in any cycle.
- Reset mid-operation clears exited, counters and held data.
- Display (ENABLE_DISPLAY=1):
  - Report prints "report(0x%08h);" with r3.
  - Putc writes the character without a newline.
  - Exit prints "exit(0x%08h)" and then calls $finish.

Test Plan:
- Reset: hold rst_n=0 with wb_valid=1 and toggling wb_insn -> all outputs 0. Release; 3 retiring 32'h14410000 -> insn_count=3, no pulses, nop_hook_count=0.
- Report: gpr_r3=32'h8000_0000, retire 32'h15000002 -> report_valid high for exactly 1 cycle, report_data=32'h8000_0000, nop_hook_count=1.
- Putc stream: retire 32'h15000004 three times back-to-back with r3 = 'H','i','\n' -> three consecutive putc_valid pulses, putc_char = 8'h48, 8'h69, 8'h0A.
- Stall: wb_insn=32'h15000002 held 5 cycles with wb_valid=1 for only 1 of them -> exactly one report pulse; insn_count advances by 1.
- Exit: r3=32'h0000_002A, retire 32'h15000001 -> exit_valid pulses, exited=1, exit_code=42. A later 32'h15000002 -> no pulse, counters frozen. Assert rst_n=0 -> exited=0.
- Non-hook: retire 32'h15000003, 32'h15010002 and 32'h15000000 -> no pulses, nop_hook_count unchanged, insn_count +3.
